// File: rtl/fpu_norm_pkg.sv
// Shared constants and types for the FPU normalization path.
// Used by norm_shift_encoder and by the barrel shifter that consumes its outputs.
package fpu_norm_pkg;

  // Default datapath widths
  localparam int SWR_DEF = 26;  // significand width incl. carry bit at MSB
  localparam int EWR_DEF = 5;   // shift-amount width
  localparam int EW_DEF  = 8;   // exponent width

  // Barrel shifter direction encoding
  localparam logic LR_RIGHT = 1'b0;
  localparam logic LR_LEFT  = 1'b1;

  // Normalization decision taken in stage 2
  typedef enum logic [1:0] {
    NORM_ZERO  = 2'd0,
    NORM_RIGHT = 2'd1,
    NORM_LEFT  = 2'd2
  } norm_case_e;

  // Pick the normalization action from the registered carry and zero flags.
  // An all-zero input always has carry clear, so zero takes priority.
  function automatic norm_case_e classify(input logic carry, input logic zero);
    norm_case_e c;
    if (zero) begin
      c = NORM_ZERO;
    end else if (carry) begin
      c = NORM_RIGHT;
    end else begin
      c = NORM_LEFT;
    end
    return c;
  endfunction

endpackage

// File: rtl/lzc_half.sv
// Combinational leading-zero counter for one half of the significand field.
// count = number of zeros above the most significant set bit; W when all zero.
module lzc_half #(
  parameter int W  = 13,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Priority encode from the MSB: scanning upward, the highest set bit wins
  always_comb begin
    count    = CW'(W);
    all_zero = ~|data;
    for (int i = 0; i < W; i++) begin
      count = data[i] ? CW'(W - 1 - i) : count;
    end
  end

endmodule

// File: rtl/norm_shift_encoder.sv
// Two-stage normalization shift encoder: turns an unnormalized adder result
// into a shift amount and direction for the barrel shifter.
// Optional macro NORM_EXP_CLAMP_EN: clamps left shifts to the current exponent
// and flags underflow (denormal result). Without it Exp_i is ignored.
module norm_shift_encoder
  import fpu_norm_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EWR = EWR_DEF,
  parameter int EW  = EW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_i,
  input  logic           valid_i,
  input  logic [SWR-1:0] Data_i,
  input  logic [EW-1:0]  Exp_i,
  output logic           valid_o,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           FSM_left_right_o,
  output logic           zero_o,
  output logic           underflow_o
);

  // Field below the carry bit is split into an upper and a lower half
  localparam int FW  = SWR - 1;
  localparam int UW  = (FW + 1) / 2;
  localparam int LW  = FW - UW;
  localparam int CWU = $clog2(UW + 1);
  localparam int CWL = $clog2(LW + 1);

  // The largest left shift is SWR-2, so EWR must be able to encode it
  if (((2 ** EWR) - 1) < (SWR - 2)) begin : g_ewr_check
    $error("norm_shift_encoder: EWR too narrow to hold SWR-2");
  end

  // ---------------- Stage 1: half-field leading-zero counts ----------------
  logic [UW-1:0]  upper_s;
  logic [LW-1:0]  lower_s;
  logic [CWU-1:0] lzc_up_s;
  logic [CWL-1:0] lzc_lo_s;
  logic           up_zero_s;
  logic           lo_zero_s;
  logic           zero_s;

  assign upper_s = Data_i[SWR-2 -: UW];
  assign lower_s = Data_i[LW-1:0];
  assign zero_s  = ~|Data_i;

  lzc_half #(.W(UW), .CW(CWU)) u_lzc_upper (
    .data     (upper_s),
    .count    (lzc_up_s),
    .all_zero (up_zero_s)
  );

  lzc_half #(.W(LW), .CW(CWL)) u_lzc_lower (
    .data     (lower_s),
    .count    (lzc_lo_s),
    .all_zero (lo_zero_s)
  );

  logic           valid_r;
  logic           carry_r;
  logic           zero_r;
  logic [CWU-1:0] lzc_up_r;
  logic [CWL-1:0] lzc_lo_r;
  logic           up_zero_r;
  logic           lo_zero_r;

  // Stage 1 register: data loads on every advancing edge, valid rides along
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= 1'b0;
      carry_r   <= 1'b0;
      zero_r    <= 1'b0;
      lzc_up_r  <= '0;
      lzc_lo_r  <= '0;
      up_zero_r <= 1'b0;
      lo_zero_r <= 1'b0;
    end else if (ce_i) begin
      valid_r   <= valid_i;
      carry_r   <= Data_i[SWR-1];
      zero_r    <= zero_s;
      lzc_up_r  <= lzc_up_s;
      lzc_lo_r  <= lzc_lo_s;
      up_zero_r <= up_zero_s;
      lo_zero_r <= lo_zero_s;
    end
  end

`ifdef NORM_EXP_CLAMP_EN
  logic [EW-1:0] exp_r;

  // Exponent travels with the stage 1 data so the clamp sees the matching value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_r <= '0;
    end else if (ce_i) begin
      exp_r <= Exp_i;
    end
  end
`else
  logic unused_exp_s;
  assign unused_exp_s = ^Exp_i;
`endif

  // ---------------- Stage 2: combine and register outputs ----------------
  localparam int CMPW = (EW > EWR) ? EW : EWR;

  logic [EWR-1:0] lzc_s;
  logic [EWR-1:0] left_shift_s;
  logic           clamp_uf_s;
  logic [EWR-1:0] shift_s;
  logic           lr_s;
  logic           zero_out_s;
  logic           uf_s;

  // Merge half counts into the leading-zero count of the whole field
  always_comb begin
    lzc_s = '0;
    if (!up_zero_r) begin
      lzc_s = EWR'(lzc_up_r);
    end else if (!lo_zero_r) begin
      lzc_s = EWR'(UW) + EWR'(lzc_lo_r);
    end else begin
      lzc_s = '0;
    end
  end

`ifdef NORM_EXP_CLAMP_EN
  // Limit the left shift to the exponent; shifting further would underflow
  always_comb begin
    left_shift_s = lzc_s;
    clamp_uf_s   = 1'b0;
    if (CMPW'(lzc_s) > CMPW'(exp_r)) begin
      left_shift_s = EWR'(exp_r);
      clamp_uf_s   = 1'b1;
    end else begin
      left_shift_s = lzc_s;
      clamp_uf_s   = 1'b0;
    end
  end
`else
  assign left_shift_s = lzc_s;
  assign clamp_uf_s   = 1'b0;
`endif

  // Select shift amount and direction for the carry / zero / left cases
  always_comb begin
    shift_s    = '0;
    lr_s       = LR_RIGHT;
    zero_out_s = 1'b0;
    uf_s       = 1'b0;
    case (classify(carry_r, zero_r))
      NORM_ZERO: begin
        shift_s    = '0;
        lr_s       = LR_LEFT;
        zero_out_s = 1'b1;
      end
      NORM_RIGHT: begin
        shift_s = EWR'(1);
        lr_s    = LR_RIGHT;
      end
      NORM_LEFT: begin
        shift_s = left_shift_s;
        lr_s    = LR_LEFT;
        uf_s    = clamp_uf_s;
      end
      default: begin
        shift_s    = '0;
        lr_s       = LR_RIGHT;
        zero_out_s = 1'b0;
        uf_s       = 1'b0;
      end
    endcase
  end

  // Stage 2 register: outputs hold while the pipeline is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o          <= 1'b0;
      Shift_Value_o    <= '0;
      FSM_left_right_o <= 1'b0;
      zero_o           <= 1'b0;
      underflow_o      <= 1'b0;
    end else if (ce_i) begin
      valid_o          <= valid_r;
      Shift_Value_o    <= shift_s;
      FSM_left_right_o <= lr_s;
      zero_o           <= zero_out_s;
      underflow_o      <= uf_s;
    end
  end

endmodule
